ddr_frame_reader: RTL and testbench

- Reads one stored camera frame back out of the external-memory frame buffer through a mux_ddr_access read port (addr/req/ready/data/data_valid) and emits it as a raster pixel stream with valid/ready.
- It is the read-side counterpart of the camera write path. It uses the same address map: 2 MB-aligned frame slots at base 0x0800_0000, slot = frame index & 0x3F, one 32-bit word per pixel, RGB565 in bits [15:0].
- Feeds display, CNN preprocessing and debug consumers.

---
 rtl/frame_reader_pkg.sv | 37 +++
 rtl/ddr_frame_reader_if.sv | 34 +++
 rtl/frame_reader_fifo.sv | 52 +++++
 rtl/ddr_frame_reader.sv | 169 ++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the DDR frame reader.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: FSM state enum, default address map, slot mask, luma coefficients
// and the RGB565 -> 8-bit luma helper used by the optional grayscale output.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0800_0000;
  localparam int          DEF_SLOT_SHIFT = 21;
  localparam logic [5:0]  SLOT_MASK      = 6'h3F;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  // Channels are widened to 8 bits by replicating their MSBs so full-scale
  // maps to 255; the weighted sum peaks at 256*255 and fits in 16 bits.
  function automatic logic [7:0] rgb565_to_y(input logic [15:0] p);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] acc;
    r8  = {p[15:11], p[15:13]};
    g8  = {p[10:5],  p[10:9]};
    b8  = {p[4:0],   p[4:2]};
    acc = 16'(LUMA_R) * 16'(r8) + 16'(LUMA_G) * 16'(g8) + 16'(LUMA_B) * 16'(b8);
    return 8'(acc >> 8);
  endfunction

endpackage

// File: rtl/ddr_frame_reader_if.sv
// Bus bundle for the frame reader: DDR read port plus the outgoing pixel stream.
// Latency: none (wiring only).
// Backpressure: DDR side by DDR_READ_READY, pixel side by PIX_READY.
// master: the frame reader (drives address/request and the pixel stream).
// slave : the memory port and pixel consumer.
interface ddr_frame_reader_if;
  logic        DDR_READ_CLK;
  logic [31:0] DDR_READ_ADDR;
  logic        DDR_READ_REQ;
  logic        DDR_READ_READY;
  logic [31:0] DDR_READ_DATA;
  logic        DDR_READ_DATA_VALID;
  logic [15:0] PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [10:0] PIX_HCNT;
  logic [10:0] PIX_VCNT;
  logic        PIX_SOF;
  logic        PIX_EOL;

  modport master (
    output DDR_READ_CLK, DDR_READ_ADDR, DDR_READ_REQ,
    input  DDR_READ_READY, DDR_READ_DATA, DDR_READ_DATA_VALID,
    output PIX_DATA, PIX_VALID, PIX_HCNT, PIX_VCNT, PIX_SOF, PIX_EOL,
    input  PIX_READY
  );

  modport slave (
    input  DDR_READ_CLK, DDR_READ_ADDR, DDR_READ_REQ,
    output DDR_READ_READY, DDR_READ_DATA, DDR_READ_DATA_VALID,
    input  PIX_DATA, PIX_VALID, PIX_HCNT, PIX_VCNT, PIX_SOF, PIX_EOL,
    output PIX_READY
  );
endinterface

// File: rtl/frame_reader_fifo.sv
// Synchronous first-word-fall-through FIFO, 16 bits wide, DEPTH entries.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: writes while full are dropped; the caller's credit scheme keeps it from filling past DEPTH.
// Ports: clk, rst_n (async, active-low); wr_en/wr_dat push; rd_en pops the head;
// rd_dat is the head, empty flags no data, count is the current occupancy.
module frame_reader_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [15:0]                wr_dat,
  input  logic                       rd_en,
  output logic [15:0]                rd_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty  = (count == '0);
  assign do_wr  = wr_en && (count != CW'(DEPTH));
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ddr_frame_reader.sv
// Reads one stored frame from the DDR frame buffer and emits it as a raster pixel stream.
// Latency: first pixel is valid the cycle after the first returned word (FWFT buffer).
// Backpressure: PIX_READY low stalls the stream; requests stop once in-flight + buffered words reach FIFO_DEPTH.
// Ports: clk, rst_n (async, active-low); start/frame_idx launch a read; busy/done
// report progress; bus carries the DDR read port and the pixel stream.
// Build option: define FRAME_READER_GRAY_EN to output {8'h00, luma} instead of raw RGB565.
module ddr_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int          H_WIDTH    = 640,
  parameter int          V_HEIGHT   = 480,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int          SLOT_SHIFT = DEF_SLOT_SHIFT,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           frame_idx,
  output logic                 busy,
  output logic                 done,
  ddr_frame_reader_if.master   bus
);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TOTAL    = 32'(H_WIDTH * V_HEIGHT);
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << SLOT_SHIFT) - 64'd1);
  localparam logic [10:0] H_LAST   = 11'(H_WIDTH - 1);

  state_t        state;
  logic [5:0]    slot;
  logic [31:0]   req_cnt;
  logic [31:0]   pix_cnt;
  logic [CW-1:0] outstanding;
  logic          req_r;
  logic [31:0]   addr_r;
  logic [10:0]   hcnt;
  logic [10:0]   vcnt;

  logic          fifo_wr;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_head;
  logic          req_acc;
  logic          pix_hs;
  logic [CW:0]   credit_next;
  logic          credit_ok;
  logic [5:0]    start_slot;
  logic [15:0]   pix_out;
  logic          unused_bits;

  assign unused_bits = &{1'b0, frame_idx[7:6], bus.DDR_READ_DATA[31:16]};

  function automatic logic [31:0] word_addr(input logic [5:0] s, input logic [31:0] n);
    return BASE_ADDR + ((32'(s) << SLOT_SHIFT) | (n & OFF_MASK));
  endfunction

  // Words returning while IDLE belong to an abandoned frame and never enter the buffer.
  assign fifo_wr    = bus.DDR_READ_DATA_VALID && (state != IDLE);
  assign req_acc    = req_r && bus.DDR_READ_READY;
  assign pix_hs     = !fifo_empty && bus.PIX_READY;
  assign start_slot = frame_idx[5:0] & SLOT_MASK;

  // Credit in use next cycle: a returning word moves from outstanding to the
  // buffer without changing the total, so only accepts add and pops remove.
  assign credit_next = {1'b0, outstanding} + {1'b0, fifo_count}
                     + (CW+1)'(req_acc) - (CW+1)'(pix_hs);
  assign credit_ok   = credit_next < (CW+1)'(FIFO_DEPTH);

  frame_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (fifo_wr),
    .wr_dat (bus.DDR_READ_DATA[15:0]),
    .rd_en  (pix_hs),
    .rd_dat (fifo_head),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      slot        <= '0;
      req_cnt     <= '0;
      pix_cnt     <= '0;
      outstanding <= '0;
      req_r       <= 1'b0;
      addr_r      <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
    end else begin
      done <= 1'b0;

      case ({req_acc, fifo_wr})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase

      if (pix_hs) begin
        pix_cnt <= pix_cnt + 32'd1;
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= vcnt + 11'd1;
        end else begin
          hcnt <= hcnt + 11'd1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            busy    <= 1'b1;
            slot    <= start_slot;
            req_cnt <= '0;
            pix_cnt <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
            req_r   <= 1'b1;
            addr_r  <= word_addr(start_slot, 32'd0);
          end
        end
        REQ: begin
          // Request and address stay put until the port accepts them.
          if (req_acc) begin
            req_cnt <= req_cnt + 32'd1;
            addr_r  <= word_addr(slot, req_cnt + 32'd1);
            if (req_cnt + 32'd1 == TOTAL) begin
              state <= DRAIN;
              req_r <= 1'b0;
            end else begin
              req_r <= credit_ok;
            end
          end else if (!req_r) begin
            req_r <= credit_ok;
          end
        end
        DRAIN: begin
          if (pix_cnt == TOTAL) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_READER_GRAY_EN
  assign pix_out = {8'h00, rgb565_to_y(fifo_head)};
`else
  assign pix_out = fifo_head;
`endif

  assign bus.DDR_READ_CLK  = clk;
  assign bus.DDR_READ_ADDR = addr_r;
  assign bus.DDR_READ_REQ  = req_r;
  assign bus.PIX_VALID     = !fifo_empty;
  assign bus.PIX_DATA      = fifo_empty ? 16'h0000 : pix_out;
  assign bus.PIX_HCNT      = hcnt;
  assign bus.PIX_VCNT      = vcnt;
  assign bus.PIX_SOF       = !fifo_empty && (hcnt == 11'd0) && (vcnt == 11'd0);
  assign bus.PIX_EOL       = !fifo_empty && (hcnt == H_LAST);
endmodule

// File: tb/tb_ddr_frame_reader.sv
// Self-checking bench for ddr_frame_reader on a 4x2 frame with a 4-deep buffer.
// A memory model answers accepted reads two cycles later; expected pixels are
// queued at request acceptance and compared at each pixel handshake.
module tb_ddr_frame_reader;
  localparam int HW    = 4;
  localparam int VH    = 2;
  localparam int DEPTH = 4;
  localparam int NPIX  = HW * VH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_idx = 8'h00;
  logic       busy;
  logic       done;

  ddr_frame_reader_if bus();

  ddr_frame_reader #(
    .H_WIDTH(HW), .V_HEIGHT(VH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_idx(frame_idx),
    .busy(busy), .done(done), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic        pix_rdy_en = 1'b1;
  logic [5:0]  exp_slot = '0;
  int          exp_k = 0;
  int          acc_cnt = 0;
  int          pix_seen = 0;
  int          done_cnt = 0;
  logic [31:0] first_addr = '0;
  bit          inject_stale = 0;
  int          due_q[$];
  logic [31:0] dat_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] obs [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [5:0] s, input int k);
    return 32'h0800_0000 + {5'd0, s, 21'd0} + 32'(k);
  endfunction

  // Memory contents: distinct per slot/offset, upper half is junk the reader must ignore.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0]  s;
    logic [20:0] off;
    logic [15:0] lo;
    s   = a[26:21];
    off = a[20:0];
    lo  = {2'b01, s, off[7:0]};
    if (s == 6'd7) begin
      case (off)
        21'd0:   lo = 16'hFFFF;
        21'd1:   lo = 16'hF800;
        21'd2:   lo = 16'h0000;
        default: ;
      endcase
    end
    return {16'hC3C3 ^ off[15:0], lo};
  endfunction

  function automatic logic [15:0] pix_model(input logic [31:0] w);
`ifdef FRAME_READER_GRAY_EN
    int r;
    int g;
    int b;
    int y;
    r = int'({w[15:11], w[15:13]});
    g = int'({w[10:5],  w[10:9]});
    b = int'({w[4:0],   w[4:2]});
    y = (77 * r + 150 * g + 29 * b) / 256;
    return 16'(y);
`else
    return w[15:0];
`endif
  endfunction

  // Memory port + pixel sink + scoreboard, evaluated on the falling edge.
  initial begin
    logic [31:0] e;
    logic [15:0] ep;
    bit          prev_req_stall;
    bit          prev_pix_stall;
    logic [31:0] prev_addr;
    logic [15:0] prev_pix;
    prev_req_stall = 0;
    prev_pix_stall = 0;
    prev_addr = '0;
    prev_pix = '0;
    bus.DDR_READ_READY = 1'b0;
    bus.DDR_READ_DATA = '0;
    bus.DDR_READ_DATA_VALID = 1'b0;
    bus.PIX_READY = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.DDR_READ_DATA_VALID = 1'b0;
      bus.DDR_READ_DATA = '0;
      if (inject_stale) begin
        bus.DDR_READ_DATA_VALID = 1'b1;
        bus.DDR_READ_DATA = 32'hBAD0_BAD0;
        inject_stale = 0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        bus.DDR_READ_DATA = dat_q.pop_front();
        bus.DDR_READ_DATA_VALID = 1'b1;
      end
      bus.DDR_READ_READY = (rdy_mode == 0) || (cyc % 3 != 1);
      bus.PIX_READY = pix_rdy_en;
      if (rst_n) begin
        if (prev_req_stall) begin
          check("req_hold", 32'(bus.DDR_READ_REQ), 32'd1);
          check("addr_hold", bus.DDR_READ_ADDR, prev_addr);
        end
        if (bus.DDR_READ_REQ && bus.DDR_READ_READY) begin
          e = exp_addr(exp_slot, exp_k);
          check("rd_addr", bus.DDR_READ_ADDR, e);
          if (exp_k == 0) first_addr = bus.DDR_READ_ADDR;
          due_q.push_back(cyc + 2);
          dat_q.push_back(mem_word(bus.DDR_READ_ADDR));
          exp_q.push_back(pix_model(mem_word(e)));
          exp_k++;
          acc_cnt++;
        end
        if (bus.PIX_VALID) begin
          if (prev_pix_stall) check("pix_hold", 32'(bus.PIX_DATA), 32'(prev_pix));
          if (bus.PIX_READY) begin
            check("pix_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              ep = exp_q.pop_front();
              check("pix_data", 32'(bus.PIX_DATA), 32'(ep));
              check("pix_hcnt", 32'(bus.PIX_HCNT), 32'(pix_seen % HW));
              check("pix_vcnt", 32'(bus.PIX_VCNT), 32'(pix_seen / HW));
              check("pix_sof", 32'(bus.PIX_SOF), 32'(pix_seen == 0));
              check("pix_eol", 32'(bus.PIX_EOL), 32'(pix_seen % HW == HW - 1));
            end
            if (pix_seen < 3) obs[pix_seen] = bus.PIX_DATA;
            pix_seen++;
          end
        end
        if (done) done_cnt++;
        prev_req_stall = bus.DDR_READ_REQ && !bus.DDR_READ_READY;
        prev_addr = bus.DDR_READ_ADDR;
        prev_pix_stall = bus.PIX_VALID && !bus.PIX_READY;
        prev_pix = bus.PIX_DATA;
      end else begin
        prev_req_stall = 0;
        prev_pix_stall = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_req"}, 32'(bus.DDR_READ_REQ), 32'd0);
    check({tag, "_addr"}, bus.DDR_READ_ADDR, 32'd0);
    check({tag, "_pvalid"}, 32'(bus.PIX_VALID), 32'd0);
    check({tag, "_pdata"}, 32'(bus.PIX_DATA), 32'd0);
    check({tag, "_hcnt"}, 32'(bus.PIX_HCNT), 32'd0);
    check({tag, "_vcnt"}, 32'(bus.PIX_VCNT), 32'd0);
    check({tag, "_sof"}, 32'(bus.PIX_SOF), 32'd0);
    check({tag, "_eol"}, 32'(bus.PIX_EOL), 32'd0);
  endtask

  task automatic do_start(input logic [7:0] idx);
    step(1);
    exp_slot = idx[5:0];
    exp_k = 0;
    acc_cnt = 0;
    pix_seen = 0;
    done_cnt = 0;
    exp_q.delete();
    start = 1'b1;
    frame_idx = idx;
    step(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      step(1);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    step(4);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_pix_count"}, 32'(pix_seen), 32'(NPIX));
    check({tag, "_req_count"}, 32'(acc_cnt), 32'(NPIX));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    step(3);
    check_zero("rst");
    rst_n = 1'b1;
    step(2);
    check_zero("idle");

    // Basic frame, slot 3.
    do_start(8'd3);
    wait_done("f3");
    check("f3_first_addr", first_addr, 32'h0860_0000);

    // Slot index is masked to 6 bits.
    do_start(8'h41);
    wait_done("f41");
    check("f41_first_addr", first_addr, 32'h0820_0000);

    // Consumer stalled: request count must stop at the buffer depth.
    pix_rdy_en = 1'b0;
    do_start(8'd2);
    step(30);
    check("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
    check("bp_req_low", 32'(bus.DDR_READ_REQ), 32'd0);
    check("bp_pvalid", 32'(bus.PIX_VALID), 32'd1);
    check("bp_no_pix", 32'(pix_seen), 32'd0);
    pix_rdy_en = 1'b1;
    wait_done("bp");

    // Port ready toggling.
    rdy_mode = 1;
    do_start(8'd4);
    wait_done("tog");
    rdy_mode = 0;

    // Pixels with known color content.
    do_start(8'd7);
    wait_done("gray");
`ifdef FRAME_READER_GRAY_EN
    check("gray_white", 32'(obs[0]), 32'h0000_00FF);
    check("gray_red", 32'(obs[1]), 32'h0000_004C);
    check("gray_black", 32'(obs[2]), 32'h0000_0000);
`else
    check("raw_white", 32'(obs[0]), 32'h0000_FFFF);
    check("raw_red", 32'(obs[1]), 32'h0000_F800);
    check("raw_black", 32'(obs[2]), 32'h0000_0000);
`endif

    // Reset while the third pixel is on the bus.
    do_start(8'd5);
    n = 0;
    while (pix_seen < 3 && n < 200) begin
      step(1);
      n++;
    end
    check("mid_reached_pix3", 32'(pix_seen >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    step(3);
    check_zero("midrst_hold");
    rst_n = 1'b1;
    n = 0;
    while (due_q.size() > 0 && n < 50) begin
      step(1);
      n++;
    end
    step(1);
    inject_stale = 1;
    step(3);
    check("stale_pvalid", 32'(bus.PIX_VALID), 32'd0);
    check("stale_busy", 32'(busy), 32'd0);
    do_start(8'd0);
    wait_done("after_rst");
    check("after_rst_first_addr", first_addr, 32'h0800_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
